// File: rtl/adder_tree_sequencer.sv
// Feeds one neuron's input chunks through a registered stage into the shared 16-input adder,
// accumulating the adder results onto a bias with signed saturation.
module adder_tree_sequencer #(
  parameter int WEIGHT_WIDTH = 16,
  parameter int NUM_CHUNKS   = 49,
  parameter int ACC_WIDTH    = 24
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ACC_WIDTH-1:0]         bias,
  input  logic [16*WEIGHT_WIDTH-1:0]   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [16*WEIGHT_WIDTH-1:0]   adder_data,
  input  logic [WEIGHT_WIDTH-1:0]      adder_sum,
  output logic [ACC_WIDTH-1:0]         out_sum,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic [9:0]                   chunk_idx
);

  localparam logic [9:0] LAST_IDX = 10'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_e;

  state_e                      state_q, state_d;
  logic [ACC_WIDTH-1:0]        acc_q, acc_d;
  logic [9:0]                  count_q, count_d;
  logic                        stage_valid_q, stage_valid_d;
  logic [16*WEIGHT_WIDTH-1:0]  adder_data_q, adder_data_d;

  logic [ACC_WIDTH:0]          sum_wide;
  logic [ACC_WIDTH-1:0]        sat_sum;

  always_comb begin
    sum_wide = {acc_q[ACC_WIDTH-1], acc_q}
             + {{(ACC_WIDTH+1-WEIGHT_WIDTH){adder_sum[WEIGHT_WIDTH-1]}}, adder_sum};
    // Sign bit and next bit disagree only on overflow; clamp toward the true sign.
    if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
      sat_sum = {sum_wide[ACC_WIDTH], {(ACC_WIDTH-1){~sum_wide[ACC_WIDTH]}}};
    end else begin
      sat_sum = sum_wide[ACC_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    count_d       = count_q;
    stage_valid_d = 1'b0;
    adder_data_d  = adder_data_q;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    out_sum       = '0;
    busy          = (state_q != IDLE);

    if (stage_valid_q) begin
      acc_d = sat_sum;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = bias;
          count_d = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          adder_data_d  = in_data;
          stage_valid_d = 1'b1;
          count_d       = count_q + 10'd1;
          if (count_q == LAST_IDX) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_sum   = acc_q;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      count_q       <= '0;
      stage_valid_q <= 1'b0;
      adder_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      count_q       <= count_d;
      stage_valid_q <= stage_valid_d;
      adder_data_q  <= adder_data_d;
    end
  end

  assign adder_data = adder_data_q;
  assign chunk_idx  = count_q;

endmodule

// File: tb/tb_adder_tree_sequencer.sv
// Scoreboard bench: three sequencer instances (4 chunks/24b, 4 chunks/20b, 1 chunk/24b), one selected per test.
module tb_adder_tree_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         rst_n, start, in_valid, out_ready;
  logic [23:0]  bias;
  logic [255:0] in_data;
  int           sel;

  int total = 0;
  int bad   = 0;
  int t0    = 0;
  bit ready_low;

  logic [255:0] chunk_q[$];
  logic [23:0]  exp_q[$];

  function automatic logic [15:0] adder16(input logic [255:0] d);
    logic [15:0] s = '0;
    for (int k = 0; k < 16; k++) s += d[k*16 +: 16];
    return s;
  endfunction

  function automatic logic [255:0] make_chunk(input logic [15:0] e0, input logic [15:0] e1,
                                              input logic [15:0] e15);
    logic [255:0] c = '0;
    c[15:0]    = e0;
    c[31:16]   = e1;
    c[255:240] = e15;
    return c;
  endfunction

  function automatic logic [23:0] model(input longint b, input int aw);
    longint acc = b;
    longint hi  = (longint'(1) <<< (aw - 1)) - 1;
    longint lo  = -(longint'(1) <<< (aw - 1));
    foreach (chunk_q[i]) begin
      acc += longint'($signed(adder16(chunk_q[i])));
      if (acc > hi) acc = hi;
      if (acc < lo) acc = lo;
    end
    return 24'(acc);
  endfunction

  // Instance A: 4 chunks, 24-bit accumulator
  logic         start_a, in_valid_a, out_ready_a, in_ready_a, out_valid_a, busy_a;
  logic [255:0] adder_data_a;
  logic [15:0]  adder_sum_a;
  logic [23:0]  out_sum_a;
  logic [9:0]   chunk_idx_a;
  assign start_a     = start && (sel == 0);
  assign in_valid_a  = in_valid && (sel == 0);
  assign out_ready_a = out_ready && (sel == 0);
  assign adder_sum_a = adder16(adder_data_a);

  adder_tree_sequencer #(.WEIGHT_WIDTH(16), .NUM_CHUNKS(4), .ACC_WIDTH(24)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bias(bias),
    .in_data(in_data), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .adder_data(adder_data_a), .adder_sum(adder_sum_a),
    .out_sum(out_sum_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .busy(busy_a), .chunk_idx(chunk_idx_a)
  );

  // Instance B: 4 chunks, 20-bit accumulator
  logic         start_b, in_valid_b, out_ready_b, in_ready_b, out_valid_b, busy_b;
  logic [255:0] adder_data_b;
  logic [15:0]  adder_sum_b;
  logic [19:0]  out_sum_b;
  logic [9:0]   chunk_idx_b;
  assign start_b     = start && (sel == 1);
  assign in_valid_b  = in_valid && (sel == 1);
  assign out_ready_b = out_ready && (sel == 1);
  assign adder_sum_b = adder16(adder_data_b);

  adder_tree_sequencer #(.WEIGHT_WIDTH(16), .NUM_CHUNKS(4), .ACC_WIDTH(20)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bias(bias[19:0]),
    .in_data(in_data), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .adder_data(adder_data_b), .adder_sum(adder_sum_b),
    .out_sum(out_sum_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .busy(busy_b), .chunk_idx(chunk_idx_b)
  );

  // Instance C: single chunk per neuron
  logic         start_c, in_valid_c, out_ready_c, in_ready_c, out_valid_c, busy_c;
  logic [255:0] adder_data_c;
  logic [15:0]  adder_sum_c;
  logic [23:0]  out_sum_c;
  logic [9:0]   chunk_idx_c;
  assign start_c     = start && (sel == 2);
  assign in_valid_c  = in_valid && (sel == 2);
  assign out_ready_c = out_ready && (sel == 2);
  assign adder_sum_c = adder16(adder_data_c);

  adder_tree_sequencer #(.WEIGHT_WIDTH(16), .NUM_CHUNKS(1), .ACC_WIDTH(24)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .bias(bias),
    .in_data(in_data), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .adder_data(adder_data_c), .adder_sum(adder_sum_c),
    .out_sum(out_sum_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
    .busy(busy_c), .chunk_idx(chunk_idx_c)
  );

  logic         in_ready_m, out_valid_m, busy_m;
  logic [23:0]  out_sum_m;
  logic [9:0]   chunk_idx_m;
  logic [255:0] adder_data_m;

  always_comb begin
    in_ready_m = in_ready_a; out_valid_m = out_valid_a; busy_m = busy_a;
    out_sum_m = out_sum_a; chunk_idx_m = chunk_idx_a; adder_data_m = adder_data_a;
    case (sel)
      1: begin
        in_ready_m = in_ready_b; out_valid_m = out_valid_b; busy_m = busy_b;
        out_sum_m = {{4{out_sum_b[19]}}, out_sum_b}; chunk_idx_m = chunk_idx_b;
        adder_data_m = adder_data_b;
      end
      2: begin
        in_ready_m = in_ready_c; out_valid_m = out_valid_c; busy_m = busy_c;
        out_sum_m = out_sum_c; chunk_idx_m = chunk_idx_c; adder_data_m = adder_data_c;
      end
      default: ;
    endcase
  end

  task automatic set_basic_chunks(input int n);
    chunk_q.delete();
    for (int i = 0; i < n; i++) chunk_q.push_back(make_chunk(16'd3, 16'd0, 16'd3));
  endtask

  task automatic begin_neuron(input int s, input longint b, input int aw, input bit push);
    sel = s;
    if (push) exp_q.push_back(model(b, aw));
    @(negedge clk);
    bias  = 24'(b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0    = cyc;
  endtask

  task automatic send_chunks(input int nmax, input bit gapped, input bit poke_start);
    int idx = 0;
    int budget = 200;
    bit gap = gapped;
    ready_low = 1'b0;
    while (idx < nmax && budget > 0) begin
      if (gap) begin
        in_valid = 1'b0;
        start    = poke_start;
        bias     = 24'h000555;
      end else begin
        in_valid = 1'b1;
        start    = 1'b0;
        in_data  = chunk_q[idx];
      end
      if (!in_ready_m) ready_low = 1'b1;
      if (in_valid && in_ready_m) idx++;
      if (gapped) gap = !gap;
      budget--;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    total++;
    if (idx < nmax) begin
      bad++;
      $display("FAIL send_chunks: accepted %0d chunks, required %0d", idx, nmax);
    end
  endtask

  task automatic wait_out(input string name, input int exp_lat, input int exp_idx, input int hold);
    int budget = 100;
    int stable_bad = 0;
    logic [23:0] exp;
    while (!out_valid_m && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    total++;
    if (out_valid_m !== 1'b1) begin
      bad++;
      $display("FAIL %s out_valid timeout: got %b, required 1", name, out_valid_m);
      return;
    end
    total++;
    if (cyc - t0 !== exp_lat) begin
      bad++;
      $display("FAIL %s latency: got %0d, required %0d", name, cyc - t0, exp_lat);
    end
    exp = exp_q.pop_front();
    total++;
    if (out_sum_m !== exp) begin
      bad++;
      $display("FAIL %s out_sum: got %h, required %h", name, out_sum_m, exp);
    end
    total++;
    if (chunk_idx_m !== 10'(exp_idx)) begin
      bad++;
      $display("FAIL %s chunk_idx: got %0d, required %0d", name, chunk_idx_m, exp_idx);
    end
    for (int h = 0; h < hold; h++) begin
      start = (h == 3);
      bias  = 24'h0003E8;
      @(negedge clk);
      if (out_valid_m !== 1'b1 || out_sum_m !== exp || busy_m !== 1'b1) stable_bad++;
    end
    start = 1'b0;
    if (hold > 0) begin
      total++;
      if (stable_bad != 0) begin
        bad++;
        $display("FAIL %s hold_stable: got %0d unstable cycles, required 0", name, stable_bad);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid_m !== 1'b0 || busy_m !== 1'b0) begin
      bad++;
      $display("FAIL %s release: got valid=%b busy=%b, required 0 0", name, out_valid_m, busy_m);
    end
    @(negedge clk);
    total++;
    if (busy_m !== 1'b0) begin
      bad++;
      $display("FAIL %s no_restart: got busy=%b, required 0", name, busy_m);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    bias = '0; in_data = '0; sel = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready_a, out_valid_a, busy_a, out_sum_a, chunk_idx_a} !== '0 || adder_data_a !== '0) begin
      bad++;
      $display("FAIL reset_a: got rdy=%b vld=%b busy=%b sum=%h idx=%0d, required all 0",
               in_ready_a, out_valid_a, busy_a, out_sum_a, chunk_idx_a);
    end
    total++;
    if ({out_valid_b, busy_b, out_valid_c, busy_c} !== 4'b0) begin
      bad++;
      $display("FAIL reset_bc: got %b, required 0000", {out_valid_b, busy_b, out_valid_c, busy_c});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    set_basic_chunks(4);
    begin_neuron(0, 0, 24, 1'b1);
    send_chunks(4, 1'b0, 1'b0);
    wait_out("basic", 5, 4, 0);
  endtask

  task automatic test_gapped();
    set_basic_chunks(4);
    begin_neuron(0, 0, 24, 1'b1);
    send_chunks(4, 1'b1, 1'b1);
    total++;
    if (ready_low !== 1'b0) begin
      bad++;
      $display("FAIL gapped in_ready: got low during ACCUM, required high");
    end
    wait_out("gapped", 9, 4, 0);
  endtask

  task automatic test_signed_bias();
    chunk_q.delete();
    for (int i = 0; i < 4; i++) chunk_q.push_back(make_chunk(16'hFFFE, 16'd5, 16'd0));
    begin_neuron(0, -100, 24, 1'b1);
    send_chunks(4, 1'b0, 1'b0);
    wait_out("signed_bias", 5, 4, 0);
  endtask

  task automatic test_saturation();
    chunk_q.delete();
    for (int i = 0; i < 4; i++) chunk_q.push_back(make_chunk(16'd8, 16'd0, 16'd0));
    begin_neuron(1, 524278, 20, 1'b1);
    send_chunks(4, 1'b0, 1'b0);
    wait_out("sat_pos", 5, 4, 0);

    chunk_q.delete();
    for (int i = 0; i < 4; i++) chunk_q.push_back(make_chunk(16'hFFF8, 16'd0, 16'd0));
    begin_neuron(1, -524278, 20, 1'b1);
    send_chunks(4, 1'b0, 1'b0);
    wait_out("sat_neg", 5, 4, 0);

    chunk_q.delete();
    chunk_q.push_back(make_chunk(16'd8, 16'd0, 16'd0));
    chunk_q.push_back(make_chunk(16'd8, 16'd0, 16'd0));
    chunk_q.push_back(make_chunk(16'hFFF8, 16'd0, 16'd0));
    chunk_q.push_back(make_chunk(16'hFFF8, 16'd0, 16'd0));
    begin_neuron(1, 524277, 20, 1'b1);
    send_chunks(4, 1'b0, 1'b0);
    wait_out("sat_resume", 5, 4, 0);
  endtask

  task automatic test_backpressure();
    set_basic_chunks(4);
    begin_neuron(0, 0, 24, 1'b1);
    send_chunks(4, 1'b0, 1'b0);
    wait_out("backpressure", 5, 4, 10);
  endtask

  task automatic test_reset_mid_op();
    int seen = 0;
    set_basic_chunks(4);
    begin_neuron(0, 500, 24, 1'b0);
    send_chunks(2, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if ({in_ready_m, out_valid_m, busy_m, out_sum_m, chunk_idx_m} !== '0 || adder_data_m !== '0) begin
      bad++;
      $display("FAIL mid_reset: got rdy=%b vld=%b busy=%b sum=%h idx=%0d, required all 0",
               in_ready_m, out_valid_m, busy_m, out_sum_m, chunk_idx_m);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid_m || busy_m) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL mid_reset quiet: got %0d active cycles, required 0", seen);
    end
    begin_neuron(0, 0, 24, 1'b1);
    send_chunks(4, 1'b0, 1'b0);
    wait_out("after_reset", 5, 4, 0);
  endtask

  task automatic test_single_chunk();
    set_basic_chunks(1);
    begin_neuron(2, 7, 24, 1'b1);
    send_chunks(1, 1'b0, 1'b0);
    wait_out("single_chunk", 2, 1, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_signed_bias();
    test_saturation();
    test_backpressure();
    test_reset_mid_op();
    test_single_chunk();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard: got %0d unconsumed results, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_tree_sequencer.md
Name: adder_tree_sequencer

Overview:
- Sequences the shared 16-input parallel adder (parallel_adder_16) across one neuron's input vector.
- Accepts NUM_CHUNKS 16-element chunks of weighted products over a valid/ready handshake and drives each chunk into the adder through a register stage.
- Accumulates the adder results onto a bias with signed saturation.
- Presents the final neuron pre-activation sum to the activation stage through a valid/ready output.

Parameters:
- WEIGHT_WIDTH, 16: element width; matches weight_width in definitions.v and the adder's sum width.
- NUM_CHUNKS, 49: chunks per neuron (784 inputs / 16); legal range 1..1023.
- ACC_WIDTH, 24: signed accumulator and output width; must be >= WEIGHT_WIDTH.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a neuron; sampled only in IDLE
- bias  in  ACC_WIDTH  signed initial accumulator value, sampled with start
- in_data  in  16*WEIGHT_WIDTH  chunk; element k at bits [(k+1)*WEIGHT_WIDTH-1 : k*WEIGHT_WIDTH]
- in_valid  in  1  in_data valid
- in_ready  out  1  sequencer accepts a chunk this cycle
- adder_data  out  16*WEIGHT_WIDTH  registered chunk to parallel_adder_16 .data
- adder_sum  in  WEIGHT_WIDTH  parallel_adder_16 .sum (combinational from adder_data)
- out_sum  out  ACC_WIDTH  signed saturated neuron sum
- out_valid  out  1  out_sum valid
- out_ready  in  1  consumer accepts out_sum
- busy  out  1  high in any state except IDLE
- chunk_idx  out  10  number of chunks accepted so far this neuron

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset:
  - state=IDLE; acc=0; count=0; stage_valid=0; adder_data=0.
  - in_ready=0, out_valid=0, out_sum=0, busy=0, chunk_idx=0.
  - Reset asserted mid-operation aborts the neuron. No partial output; no out_valid pulse.
- States: IDLE, ACCUM, FLUSH, DONE.
- IDLE:
  - start=1 -> acc<=bias, count<=0, next ACCUM.
  - in_ready=0.
  - in_valid is ignored.
- ACCUM:
  - in_ready=1.
  - On in_valid&&in_ready: adder_data<=in_data, stage_valid<=1, count<=count+1.
  - Otherwise stage_valid<=0 and adder_data holds its value.
  - When the chunk accepted is the last one (count==NUM_CHUNKS-1) -> next FLUSH; in_ready=0 from the next cycle.
- Accumulate stage, any state:
  - If stage_valid=1: acc <= sat(acc + sext(adder_sum)).
  - adder_sum is treated as signed WEIGHT_WIDTH. Overflow inside the adder wraps and is not detected here.
- FLUSH:
  - Exactly one cycle; the last chunk's add lands on this cycle's edge.
  - Next DONE.
- DONE:
  - out_valid=1, out_sum=acc.
  - Both hold stable until out_ready=1 is sampled.
  - On out_valid&&out_ready -> IDLE; out_valid drops next cycle.
- Saturation:
  - Sum is computed at ACC_WIDTH+1 bits.
  - Positive overflow clamps to 2^(ACC_WIDTH-1)-1; negative overflow clamps to -2^(ACC_WIDTH-1).
  - Once clamped, later adds still apply normally from the clamped value.
- Latency:
  - Start sampled at cycle T, in_valid held high -> chunks accepted T+1..T+NUM_CHUNKS.
  - out_valid first high at T+NUM_CHUNKS+2.
- Boundary conditions:
  - start while busy: ignored; bias is not re-sampled.
  - NUM_CHUNKS=1: ACCUM lasts one accept, then FLUSH, then DONE.
  - in_valid gaps: no count change; no add.
- chunk_idx = count. It reads NUM_CHUNKS in FLUSH and DONE and resets to 0 on the next start.

Test Plan:
1. Basic: NUM_CHUNKS=4, bias=0; each chunk has element0=3, element15=3, others 0; in_valid held; start at T -> out_valid at T+6, out_sum=24, chunk_idx=4.
2. Gapped input: same data as scenario 1, but in_valid high only on alternate cycles -> in_ready high throughout ACCUM; out_sum=24; out_valid 4 cycles later than in scenario 1.
3. Signed/bias: bias=-100; chunks have element0=16'hFFFE (-2) and element1=5 -> 4 chunks add +12 -> out_sum=-88 (24'hFFFFA8).
4. Saturation: ACC_WIDTH=20, bias=2^19-10, each chunk sum=+8 -> out_sum=524287 (20'h7FFFF). Mirror case with negative bias and -8 chunks -> out_sum=-524288.
5. Backpressure/start ignore: out_ready=0 for 10 cycles in DONE, with start pulsed during DONE -> out_valid and out_sum stable; no restart; after out_ready=1, IDLE next cycle and busy=0.
6. Reset mid-op: rst_n=0 for one cycle after 2 chunks accepted -> next cycle all outputs 0 and state IDLE; a fresh start with scenario-1 data gives out_sum=24, with no residue from the aborted neuron.
